pipeline_credit_gate: RTL and testbench

Parametrised successor to the single-token pipeline mutex. It admits up to MAX_OUTSTANDING transactions into a downstream multi-cycle datapath (e.g. Montgomery / RSA loop) before stalling the producer, and returns one credit per o_done pulse. It carries a DATA_W payload through a one-entry forward register slice with a valid/ready handshake. It sits between a pipeline stage and the engine that signals completion.

---
 rtl/pipeline_credit_gate_if.sv | 41 ++++
 rtl/pipeline_credit_gate.sv | 104 ++++++++++
 tb/tb_pipeline_credit_gate.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_credit_gate_if.sv
// Handshake bundle for pipeline_credit_gate. The o_timeout signal exists only
// when PIPELINE_CREDIT_GATE_WATCHDOG_EN is defined.
interface pipeline_credit_gate_if #(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_cen;
  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_done;
  logic [CNT_W-1:0]  o_cnt;
  logic              o_busy;
  logic              o_err;
`ifdef PIPELINE_CREDIT_GATE_WATCHDOG_EN
  logic              o_timeout;
`endif

  // Environment side: producer, consumer and completion engine.
  modport master (
    output i_valid, i_data, o_ready, o_done,
    input  i_ready, i_cen, o_valid, o_data, o_cnt, o_busy, o_err
`ifdef PIPELINE_CREDIT_GATE_WATCHDOG_EN
    , input o_timeout
`endif
  );

  // Gate side.
  modport slave (
    input  i_valid, i_data, o_ready, o_done,
    output i_ready, i_cen, o_valid, o_data, o_cnt, o_busy, o_err
`ifdef PIPELINE_CREDIT_GATE_WATCHDOG_EN
    , output o_timeout
`endif
  );
endinterface

// File: rtl/pipeline_credit_gate.sv
// Credit gate: admits up to MAX_OUTSTANDING transactions through a one-entry
// register slice. Optional watchdog via PIPELINE_CREDIT_GATE_WATCHDOG_EN.
module pipeline_credit_gate #(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYC     = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_credit_gate_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              err_r;
  logic              ready_s;
  logic              cen_s;
  logic              dec_s;
  logic              underflow_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  // Handshake and credit decisions from registered state.
  always_comb begin
    ready_s     = 1'b0;
    cen_s       = 1'b0;
    dec_s       = 1'b0;
    underflow_s = 1'b0;
    if ((!valid_r || bus.o_ready) && (cnt_r < MAX_CNT)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    cen_s = bus.i_valid && ready_s;
    if (bus.o_done) begin
      dec_s       = (cnt_r != {CNT_W{1'b0}});
      underflow_s = (cnt_r == {CNT_W{1'b0}});
    end else begin
      dec_s       = 1'b0;
      underflow_s = 1'b0;
    end
  end

  // Next credit count; simultaneous accept and return cancel out.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({cen_s, dec_s})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Output slice, credit counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (cen_s) begin
        valid_r <= 1'b1;
        data_r  <= bus.i_data;
      end else if (valid_r && bus.o_ready) begin
        valid_r <= 1'b0;
      end
      cnt_r <= cnt_nxt_s;
      if (underflow_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.i_ready = ready_s;
  assign bus.i_cen   = cen_s;
  assign bus.o_valid = valid_r;
  assign bus.o_data  = data_r;
  assign bus.o_cnt   = cnt_r;
  assign bus.o_busy  = (cnt_r != {CNT_W{1'b0}});
  assign bus.o_err   = err_r;

`ifdef PIPELINE_CREDIT_GATE_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_r;

  // Idle or completion restarts the watchdog; otherwise count up and saturate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_r <= {WD_W{1'b0}};
    end else if (bus.o_done || (cnt_r == {CNT_W{1'b0}})) begin
      wd_r <= {WD_W{1'b0}};
    end else if (wd_r != WD_MAX) begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  assign bus.o_timeout = (wd_r == WD_MAX);
`endif
endmodule

// File: tb/tb_pipeline_credit_gate.sv
// Directed self-checking bench for pipeline_credit_gate (MAX_OUTSTANDING=4).
// Watchdog steps run only when PIPELINE_CREDIT_GATE_WATCHDOG_EN is defined.
module tb_pipeline_credit_gate;
  localparam int DATA_W = 32;
  localparam int MAXO   = 4;
  localparam int TMO    = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pipeline_credit_gate_if #(.DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) bus ();

  pipeline_credit_gate #(
    .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = 32'h0;
    bus.o_ready = 1'b1;
    bus.o_done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data", bus.o_data, 32'h0);
    chk("rst_cnt", 32'(bus.o_cnt), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    chk("rst_ready", 32'(bus.i_ready), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);

    // Fill all four credits back to back.
    bus.i_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_data = 32'h100 + 32'(k);
      #1;
      chk("fill_cen", 32'(bus.i_cen), 32'd1);
      tick();
      chk("fill_cnt", 32'(bus.o_cnt), 32'(k + 1));
      chk("fill_valid", 32'(bus.o_valid), 32'd1);
      chk("fill_data", bus.o_data, 32'h100 + 32'(k));
    end
    chk("full_ready", 32'(bus.i_ready), 32'd0);
    chk("full_cen", 32'(bus.i_cen), 32'd0);
    chk("full_busy", 32'(bus.o_busy), 32'd1);
    tick();
    chk("full_hold_cnt", 32'(bus.o_cnt), 32'd4);

    // Credit return while full: ready only on the following cycle.
    bus.o_done = 1'b1;
    #1;
    chk("done_same_cycle_ready", 32'(bus.i_ready), 32'd0);
    tick();
    bus.o_done = 1'b0;
    bus.i_data = 32'h200;
    #1;
    chk("ret_cnt", 32'(bus.o_cnt), 32'd3);
    chk("ret_ready", 32'(bus.i_ready), 32'd1);
    chk("ret_cen", 32'(bus.i_cen), 32'd1);
    tick();
    bus.i_valid = 1'b0;
    chk("refill_cnt", 32'(bus.o_cnt), 32'd4);
    chk("refill_data", bus.o_data, 32'h200);

    // Drop to two credits, then accept and return together.
    bus.o_done = 1'b1;
    tick();
    tick();
    chk("drain2_cnt", 32'(bus.o_cnt), 32'd2);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h300;
    #1;
    chk("both_cen", 32'(bus.i_cen), 32'd1);
    tick();
    bus.o_done = 1'b0;
    chk("both_cnt", 32'(bus.o_cnt), 32'd2);
    chk("both_data", bus.o_data, 32'h300);

    // Backpressure holds the slice.
    bus.i_data = 32'hDEADBEEF;
    tick();
    chk("bp_cnt", 32'(bus.o_cnt), 32'd3);
    bus.o_ready = 1'b0;
    bus.i_data  = 32'h12345678;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready", 32'(bus.i_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_data", bus.o_data, 32'hDEADBEEF);
    end
    chk("bp_cnt_hold", 32'(bus.o_cnt), 32'd3);
    bus.o_ready = 1'b1;
    #1;
    chk("release_ready", 32'(bus.i_ready), 32'd1);
    chk("release_cen", 32'(bus.i_cen), 32'd1);
    tick();
    bus.i_valid = 1'b0;
    chk("release_data", bus.o_data, 32'h12345678);
    chk("release_cnt", 32'(bus.o_cnt), 32'd4);
    tick();
    chk("drain_valid", 32'(bus.o_valid), 32'd0);

    // Drain to zero, then underflow.
    bus.o_done = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("empty_cnt", 32'(bus.o_cnt), 32'd0);
    chk("empty_err", 32'(bus.o_err), 32'd0);
    tick();
    chk("uf_cnt", 32'(bus.o_cnt), 32'd0);
    chk("uf_err", 32'(bus.o_err), 32'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h55;
    tick();
    bus.i_valid = 1'b0;
    chk("uf_cen_cnt", 32'(bus.o_cnt), 32'd1);
    tick();
    bus.o_done = 1'b0;
    chk("uf_norm_cnt", 32'(bus.o_cnt), 32'd0);
    chk("uf_sticky", 32'(bus.o_err), 32'd1);

    // Synchronous reset clears everything.
    rst_n       = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h77;
    tick();
    rst_n       = 1'b1;
    bus.i_valid = 1'b0;
    #1;
    chk("rst2_err", 32'(bus.o_err), 32'd0);
    chk("rst2_cnt", 32'(bus.o_cnt), 32'd0);
    chk("rst2_valid", 32'(bus.o_valid), 32'd0);
    chk("rst2_data", bus.o_data, 32'h0);
    chk("rst2_ready", 32'(bus.i_ready), 32'd1);

`ifdef PIPELINE_CREDIT_GATE_WATCHDOG_EN
    bus.i_valid = 1'b1;
    bus.i_data  = 32'h99;
    tick();
    bus.i_valid = 1'b0;
    chk("wd_cnt", 32'(bus.o_cnt), 32'd1);
    for (int k = 0; k < TMO - 1; k++) tick();
    chk("wd_early", 32'(bus.o_timeout), 32'd0);
    tick();
    chk("wd_fire", 32'(bus.o_timeout), 32'd1);
    bus.o_done = 1'b1;
    tick();
    bus.o_done = 1'b0;
    chk("wd_clear", 32'(bus.o_timeout), 32'd0);
    chk("wd_cnt0", 32'(bus.o_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
